// File: rtl/stage_mem_wb_reg.sv
// MEM/WB pipeline register: aligns and extends DMEM load data, flags faulting loads,
// and registers the EX/MEM results for the writeback stage.
module stage_mem_wb_reg #(
    parameter int REG_WIDTH = 32,
    parameter int RD_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 EX_MEM_valid,
    input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
    input  logic                 EX_MEM_reg_wb_sel,
    input  logic                 EX_MEM_reg_wen,
    input  logic [RD_WIDTH-1:0]  EX_MEM_rd,
    input  logic                 EX_MEM_mem_read,
    input  logic [2:0]           EX_MEM_funct3,
    input  logic [REG_WIDTH-1:0] dmem_rdata,
    output logic                 MEM_WB_valid,
    output logic                 MEM_WB_reg_wb_sel,
    output logic [REG_WIDTH-1:0] MEM_WB_alu_out,
    output logic [REG_WIDTH-1:0] MEM_WB_data_out,
    output logic                 MEM_WB_reg_wen,
    output logic [RD_WIDTH-1:0]  MEM_WB_rd,
    output logic                 MEM_WB_load_fault
);

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_kind_e;

    logic [1:0]           byte_addr;
    logic [7:0]           load_byte;
    logic [15:0]          load_half;
    logic [REG_WIDTH-1:0] ext_data;
    logic                 illegal_f3;
    logic                 misaligned;
    logic                 is_load;
    logic                 load_fault;
    logic [REG_WIDTH-1:0] next_data;
    logic                 next_wen;

    assign byte_addr = EX_MEM_alu_out[1:0];

    always_comb begin
        load_byte  = 8'h00;
        load_half  = 16'h0000;
        ext_data   = '0;
        illegal_f3 = 1'b0;
        misaligned = 1'b0;

        case (byte_addr)
            2'd0:    load_byte = dmem_rdata[7:0];
            2'd1:    load_byte = dmem_rdata[15:8];
            2'd2:    load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_half = byte_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (EX_MEM_funct3)
            F3_LB:  ext_data = {{(REG_WIDTH-8){load_byte[7]}}, load_byte};
            F3_LBU: ext_data = {{(REG_WIDTH-8){1'b0}}, load_byte};
            F3_LH: begin
                ext_data   = {{(REG_WIDTH-16){load_half[15]}}, load_half};
                misaligned = byte_addr[0];
            end
            F3_LHU: begin
                ext_data   = {{(REG_WIDTH-16){1'b0}}, load_half};
                misaligned = byte_addr[0];
            end
            F3_LW: begin
                ext_data   = dmem_rdata;
                misaligned = (byte_addr != 2'b00);
            end
            default: illegal_f3 = 1'b1;
        endcase

        // Faulting or non-load instructions never carry load data forward
        is_load    = EX_MEM_valid & EX_MEM_mem_read;
        load_fault = is_load & (illegal_f3 | misaligned);
        next_data  = (is_load && !load_fault) ? ext_data : '0;
        next_wen   = EX_MEM_valid & EX_MEM_reg_wen & (EX_MEM_rd != '0) & ~load_fault;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MEM_WB_valid      <= 1'b0;
            MEM_WB_reg_wb_sel <= 1'b0;
            MEM_WB_alu_out    <= '0;
            MEM_WB_data_out   <= '0;
            MEM_WB_reg_wen    <= 1'b0;
            MEM_WB_rd         <= '0;
            MEM_WB_load_fault <= 1'b0;
        end else if (flush || (!stall && !EX_MEM_valid)) begin
            // Flushes and invalid slots both become an all-zero bubble
            MEM_WB_valid      <= 1'b0;
            MEM_WB_reg_wb_sel <= 1'b0;
            MEM_WB_alu_out    <= '0;
            MEM_WB_data_out   <= '0;
            MEM_WB_reg_wen    <= 1'b0;
            MEM_WB_rd         <= '0;
            MEM_WB_load_fault <= 1'b0;
        end else if (!stall) begin
            MEM_WB_valid      <= 1'b1;
            MEM_WB_reg_wb_sel <= EX_MEM_reg_wb_sel;
            MEM_WB_alu_out    <= EX_MEM_alu_out;
            MEM_WB_data_out   <= next_data;
            MEM_WB_reg_wen    <= next_wen;
            MEM_WB_rd         <= EX_MEM_rd;
            MEM_WB_load_fault <= load_fault;
        end
    end

endmodule

// File: tb/tb_stage_mem_wb_reg.sv
// Directed testbench for stage_mem_wb_reg: load extraction, faults, stall/flush and reset.
module tb_stage_mem_wb_reg;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_alu_out;
    logic        ex_wb_sel;
    logic        ex_reg_wen;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic [2:0]  ex_funct3;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_wb_sel;
    logic [31:0] wb_alu_out;
    logic [31:0] wb_data_out;
    logic        wb_reg_wen;
    logic [4:0]  wb_rd;
    logic        wb_load_fault;

    int checks   = 0;
    int failures = 0;

    stage_mem_wb_reg #(.REG_WIDTH(32), .RD_WIDTH(5)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .stall             (stall),
        .flush             (flush),
        .EX_MEM_valid      (ex_valid),
        .EX_MEM_alu_out    (ex_alu_out),
        .EX_MEM_reg_wb_sel (ex_wb_sel),
        .EX_MEM_reg_wen    (ex_reg_wen),
        .EX_MEM_rd         (ex_rd),
        .EX_MEM_mem_read   (ex_mem_read),
        .EX_MEM_funct3     (ex_funct3),
        .dmem_rdata        (dmem_rdata),
        .MEM_WB_valid      (wb_valid),
        .MEM_WB_reg_wb_sel (wb_wb_sel),
        .MEM_WB_alu_out    (wb_alu_out),
        .MEM_WB_data_out   (wb_data_out),
        .MEM_WB_reg_wen    (wb_reg_wen),
        .MEM_WB_rd         (wb_rd),
        .MEM_WB_load_fault (wb_load_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [31:0] addr, input logic wb_sel,
                                 input logic wen, input logic [4:0] rd, input logic mem_read,
                                 input logic [2:0] f3, input logic [31:0] rdata);
        ex_valid    = v;
        ex_alu_out  = addr;
        ex_wb_sel   = wb_sel;
        ex_reg_wen  = wen;
        ex_rd       = rd;
        ex_mem_read = mem_read;
        ex_funct3   = f3;
        dmem_rdata  = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 32'h0);
        #12;
        checks++; if ({wb_valid, wb_reg_wen, wb_load_fault, wb_wb_sel} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags actual=%b required=0000", {wb_valid, wb_reg_wen, wb_load_fault, wb_wb_sel}); end
        checks++; if ({wb_alu_out, wb_data_out, wb_rd} !== 69'd0) begin failures++; $display("[TB] FAIL reset_data actual=%h/%h/%h required=0", wb_alu_out, wb_data_out, wb_rd); end
        reset_n = 1'b1;
        // Capture a nonzero LW, then pull reset mid-cycle
        applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b1, 5'd9, 1'b1, 3'b010, 32'hCAFE_F00D);
        tick();
        checks++; if (wb_data_out !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL pre_reset_data actual=%h required=cafef00d", wb_data_out); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({wb_valid, wb_reg_wen, wb_rd, wb_data_out, wb_alu_out} !== 71'd0) begin failures++; $display("[TB] FAIL async_reset actual=%b/%b/%h/%h/%h required=0", wb_valid, wb_reg_wen, wb_rd, wb_data_out, wb_alu_out); end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_byte_loads();
        applyStimulus(1'b1, 32'h0000_1003, 1'b0, 1'b1, 5'd7, 1'b1, 3'b000, 32'h80AB_CDEF);
        tick();
        checks++; if (wb_data_out !== 32'hFFFF_FF80) begin failures++; $display("[TB] FAIL lb_data actual=%h required=ffffff80", wb_data_out); end
        checks++; if ({wb_valid, wb_reg_wen, wb_load_fault, wb_rd} !== {3'b110, 5'd7}) begin failures++; $display("[TB] FAIL lb_ctrl actual=%b%b%b rd=%0d required=110 rd=7", wb_valid, wb_reg_wen, wb_load_fault, wb_rd); end
        checks++; if (wb_alu_out !== 32'h0000_1003) begin failures++; $display("[TB] FAIL lb_alu actual=%h required=00001003", wb_alu_out); end
        ex_funct3 = 3'b100;
        tick();
        checks++; if (wb_data_out !== 32'h0000_0080) begin failures++; $display("[TB] FAIL lbu_data actual=%h required=00000080", wb_data_out); end
        ex_funct3  = 3'b000;
        ex_alu_out = 32'h0000_1001;
        tick();
        checks++; if (wb_data_out !== 32'hFFFF_FFCD) begin failures++; $display("[TB] FAIL lb_byte1 actual=%h required=ffffffcd", wb_data_out); end
        ex_alu_out = 32'h0000_1002;
        tick();
        checks++; if (wb_data_out !== 32'hFFFF_FFAB) begin failures++; $display("[TB] FAIL lb_byte2 actual=%h required=ffffffab", wb_data_out); end
    endtask

    task automatic test_half_loads();
        applyStimulus(1'b1, 32'h0000_2001, 1'b0, 1'b1, 5'd5, 1'b1, 3'b001, 32'h1234_5678);
        tick();
        checks++; if ({wb_load_fault, wb_reg_wen, wb_valid} !== 3'b101) begin failures++; $display("[TB] FAIL lh_misalign_ctrl actual=%b%b%b required=101", wb_load_fault, wb_reg_wen, wb_valid); end
        checks++; if (wb_data_out !== 32'h0) begin failures++; $display("[TB] FAIL lh_misalign_data actual=%h required=00000000", wb_data_out); end
        applyStimulus(1'b1, 32'h0000_2002, 1'b0, 1'b1, 5'd5, 1'b1, 3'b101, 32'h1234_5678);
        tick();
        checks++; if (wb_data_out !== 32'h0000_1234) begin failures++; $display("[TB] FAIL lhu_data actual=%h required=00001234", wb_data_out); end
        checks++; if ({wb_load_fault, wb_reg_wen} !== 2'b01) begin failures++; $display("[TB] FAIL lhu_ctrl actual=%b%b required=01", wb_load_fault, wb_reg_wen); end
        applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b1, 5'd5, 1'b1, 3'b001, 32'h1234_9ABC);
        tick();
        checks++; if (wb_data_out !== 32'hFFFF_9ABC) begin failures++; $display("[TB] FAIL lh_sign actual=%h required=ffff9abc", wb_data_out); end
        applyStimulus(1'b1, 32'h0000_2003, 1'b0, 1'b1, 5'd5, 1'b1, 3'b101, 32'h1234_9ABC);
        tick();
        checks++; if ({wb_load_fault, wb_data_out} !== {1'b1, 32'h0}) begin failures++; $display("[TB] FAIL lhu_misalign actual=%b/%h required=1/00000000", wb_load_fault, wb_data_out); end
    endtask

    task automatic test_stall_flush();
        applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b1, 5'd10, 1'b1, 3'b010, 32'hDEAD_BEEF);
        tick();
        checks++; if ({wb_data_out, wb_rd, wb_reg_wen} !== {32'hDEAD_BEEF, 5'd10, 1'b1}) begin failures++; $display("[TB] FAIL lw_capture actual=%h rd=%0d wen=%b required=deadbeef rd=10 wen=1", wb_data_out, wb_rd, wb_reg_wen); end
        stall = 1'b1;
        applyStimulus(1'b1, 32'h0000_3004, 1'b1, 1'b1, 5'd11, 1'b1, 3'b000, 32'h1111_2222);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({wb_data_out, wb_alu_out, wb_rd, wb_wb_sel, wb_valid} !== {32'hDEAD_BEEF, 32'h0000_3000, 5'd10, 1'b0, 1'b1}) begin failures++; $display("[TB] FAIL stall_hold_%0d actual=%h/%h/%0d/%b/%b required=deadbeef/00003000/10/0/1", i, wb_data_out, wb_alu_out, wb_rd, wb_wb_sel, wb_valid); end
        end
        flush = 1'b1;
        tick();
        checks++; if ({wb_valid, wb_reg_wen, wb_load_fault} !== 3'b000) begin failures++; $display("[TB] FAIL flush_over_stall actual=%b%b%b required=000", wb_valid, wb_reg_wen, wb_load_fault); end
        checks++; if ({wb_data_out, wb_alu_out, wb_rd} !== 69'd0) begin failures++; $display("[TB] FAIL flush_data actual=%h/%h/%h required=0", wb_data_out, wb_alu_out, wb_rd); end
        flush = 1'b0;
        stall = 1'b0;
        // Misaligned LW, then reset while stalled must drop the held fault
        applyStimulus(1'b1, 32'h0000_3002, 1'b0, 1'b1, 5'd12, 1'b1, 3'b010, 32'hDEAD_BEEF);
        tick();
        checks++; if ({wb_load_fault, wb_reg_wen, wb_data_out} !== {2'b10, 32'h0}) begin failures++; $display("[TB] FAIL lw_misalign actual=%b%b/%h required=10/00000000", wb_load_fault, wb_reg_wen, wb_data_out); end
        stall = 1'b1;
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({wb_valid, wb_load_fault, wb_rd, wb_alu_out} !== 39'd0) begin failures++; $display("[TB] FAIL reset_mid_stall actual=%b%b/%h/%h required=0", wb_valid, wb_load_fault, wb_rd, wb_alu_out); end
        #1 reset_n = 1'b1;
        stall = 1'b0;
    endtask

    task automatic test_alu_and_bubbles();
        applyStimulus(1'b1, 32'h0000_0055, 1'b1, 1'b1, 5'd0, 1'b0, 3'b011, 32'hFFFF_FFFF);
        tick();
        checks++; if ({wb_alu_out, wb_data_out} !== {32'h0000_0055, 32'h0}) begin failures++; $display("[TB] FAIL alu_x0_data actual=%h/%h required=00000055/00000000", wb_alu_out, wb_data_out); end
        checks++; if ({wb_valid, wb_wb_sel, wb_reg_wen, wb_load_fault} !== 4'b1100) begin failures++; $display("[TB] FAIL alu_x0_ctrl actual=%b%b%b%b required=1100", wb_valid, wb_wb_sel, wb_reg_wen, wb_load_fault); end
        ex_rd = 5'd3;
        tick();
        checks++; if ({wb_reg_wen, wb_rd, wb_data_out} !== {1'b1, 5'd3, 32'h0}) begin failures++; $display("[TB] FAIL alu_rd3 actual=%b rd=%0d data=%h required=1 rd=3 data=0", wb_reg_wen, wb_rd, wb_data_out); end
        applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b1, 5'd8, 1'b1, 3'b011, 32'h7777_7777);
        tick();
        checks++; if ({wb_load_fault, wb_reg_wen, wb_data_out} !== {2'b10, 32'h0}) begin failures++; $display("[TB] FAIL illegal_f3 actual=%b%b/%h required=10/00000000", wb_load_fault, wb_reg_wen, wb_data_out); end
        ex_funct3 = 3'b111;
        tick();
        checks++; if (wb_load_fault !== 1'b1) begin failures++; $display("[TB] FAIL illegal_f3_111 actual=%b required=1", wb_load_fault); end
        ex_valid = 1'b0;
        tick();
        checks++; if ({wb_valid, wb_load_fault, wb_reg_wen, wb_data_out} !== {3'b000, 32'h0}) begin failures++; $display("[TB] FAIL bubble actual=%b%b%b/%h required=000/00000000", wb_valid, wb_load_fault, wb_reg_wen, wb_data_out); end
    endtask

    initial begin
        test_reset();
        test_byte_loads();
        test_half_loads();
        test_stall_flush();
        test_alu_and_bubbles();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
